// File: rtl/fc_sched_pkg.sv
// Shared types and helpers for the fully-connected layer scheduler.
// The token carries per-pair sideband from issue down to the MAC and write-back stages.
package fc_sched_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Never returns less than 1, so that degenerate sizes still give legal port widths.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    function automatic int pairs_per_group(input int inneuron);
        return inneuron / 2;
    endfunction

    function automatic int pairs_per_bank(input int inneuron, input int pi);
        return inneuron / (2 * pi);
    endfunction

    function automatic int num_groups(input int outneuron, input int po);
        return outneuron / po;
    endfunction

    localparam int DEF_INNEURON    = 800;
    localparam int DEF_OUTNEURON   = 500;
    localparam int DEF_PI          = 4;
    localparam int DEF_PO          = 2;
    localparam int PAIRS_PER_GROUP = pairs_per_group(DEF_INNEURON);
    localparam int PAIRS_PER_BANK  = pairs_per_bank(DEF_INNEURON, DEF_PI);
    localparam int NUM_GROUPS      = num_groups(DEF_OUTNEURON, DEF_PO);

    localparam int TOK_BANK_W = 8;
    localparam int TOK_G_W    = 16;

    typedef struct packed {
        logic                  valid;
        logic                  first;
        logic                  last;
        logic [TOK_BANK_W-1:0] bank;
        logic [TOK_G_W-1:0]    g;
    } tok_t;

endpackage

// File: rtl/fc_sched_pipe.sv
// Stall-aware token delay line covering RAM read latency, followed by the
// write-back delay that times out_wr_en after the last MAC of a group.
module fc_sched_pipe
    import fc_sched_pkg::*;
#(
    parameter int RD_LATENCY  = 2,
    parameter int MAC_LATENCY = 1,
    parameter int BANK_W      = 2,
    parameter int G_W         = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  tok_t              issue_tok,
    output logic              mac_en,
    output logic              accum_sload,
    output logic [BANK_W-1:0] mux_sel,
    output logic              wb_en,
    output logic [G_W-1:0]    wb_g,
    output logic              empty
);

    tok_t rd_q [RD_LATENCY];
    tok_t rd_d [RD_LATENCY];
    tok_t wb_q [MAC_LATENCY];
    tok_t wb_d [MAC_LATENCY];

    always_comb begin
        rd_d = rd_q;
        wb_d = wb_q;
        if (!stall) begin
            rd_d[0] = issue_tok;
            for (int i = 1; i < RD_LATENCY; i++) rd_d[i] = rd_q[i-1];
            wb_d[0]       = '0;
            wb_d[0].valid = rd_q[RD_LATENCY-1].valid & rd_q[RD_LATENCY-1].last;
            wb_d[0].g     = rd_q[RD_LATENCY-1].g;
            for (int i = 1; i < MAC_LATENCY; i++) wb_d[i] = wb_q[i-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) rd_q[i] <= '0;
            for (int i = 0; i < MAC_LATENCY; i++) wb_q[i] <= '0;
        end else begin
            rd_q <= rd_d;
            wb_q <= wb_d;
        end
    end

    assign mac_en      = rd_q[RD_LATENCY-1].valid & ~stall;
    assign accum_sload = mac_en & rd_q[RD_LATENCY-1].first;
    assign mux_sel     = rd_q[RD_LATENCY-1].bank[BANK_W-1:0];
    assign wb_en       = wb_q[MAC_LATENCY-1].valid & ~stall;
    assign wb_g        = wb_q[MAC_LATENCY-1].g[G_W-1:0];

    // Empty except for whatever sits in the final write-back slot.
    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < RD_LATENCY; i++)
            if (rd_q[i].valid) empty = 1'b0;
        for (int i = 0; i < MAC_LATENCY - 1; i++)
            if (wb_q[i].valid) empty = 1'b0;
    end

endmodule

// File: rtl/fc_layer_scheduler.sv
// Issues input-neuron / weight RAM reads for one FC layer pass, two inputs per
// cycle for PO outputs in parallel, and steers the MAC datapath through a delay line.
module fc_layer_scheduler
    import fc_sched_pkg::*;
#(
    parameter int INNEURON    = 800,
    parameter int OUTNEURON   = 500,
    parameter int PI          = 4,
    parameter int PO          = 2,
    parameter int RD_LATENCY  = 2,
    parameter int MAC_LATENCY = 1,
    localparam int AW = clog2(INNEURON / (2 * PI)),
    localparam int WW = clog2(OUTNEURON / PO * INNEURON / 2),
    localparam int MW = clog2(PI),
    localparam int GW = clog2(OUTNEURON / PO)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    output logic          busy,
    output logic          done,
    output logic          in_rden,
    output logic [AW-1:0] in_addr_a,
    output logic [AW-1:0] in_addr_b,
    output logic          w_rden,
    output logic [WW-1:0] w_addr,
    output logic [MW-1:0] mux_sel,
    output logic          mac_en,
    output logic          accum_sload,
    output logic          out_wr_en,
    output logic [GW-1:0] out_wr_addr
);

    localparam int PPB = pairs_per_bank(INNEURON, PI);
    localparam int NG  = num_groups(OUTNEURON, PO);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [MW-1:0] bank_q, bank_d;
    logic [GW-1:0] g_q, g_d;
    logic [WW-1:0] w_q, w_d;

    logic issue, last_pair, last_group, pipe_empty;
    tok_t issue_tok;

    assign issue      = (state_q == RUN) && !stall;
    assign last_pair  = (addr_q == AW'(PPB - 1)) && (bank_q == MW'(PI - 1));
    assign last_group = (g_q == GW'(NG - 1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        bank_d  = bank_q;
        g_d     = g_q;
        w_d     = w_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                addr_d  = '0;
                bank_d  = '0;
                g_d     = '0;
                w_d     = '0;
            end
            RUN: if (issue) begin
                w_d = w_q + 1'b1;
                if (addr_q == AW'(PPB - 1)) begin
                    addr_d = '0;
                    if (last_pair) begin
                        bank_d = '0;
                        if (last_group) begin
                            g_d     = '0;
                            w_d     = '0;
                            state_d = DRAIN;
                        end else begin
                            g_d = g_q + 1'b1;
                        end
                    end else begin
                        bank_d = bank_q + 1'b1;
                    end
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            // The final group's write-back is the last thing left in flight.
            DRAIN: if (pipe_empty && out_wr_en) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            bank_q  <= '0;
            g_q     <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bank_q  <= bank_d;
            g_q     <= g_d;
            w_q     <= w_d;
        end
    end

    always_comb begin
        issue_tok       = '0;
        issue_tok.valid = issue;
        issue_tok.first = issue && (addr_q == '0) && (bank_q == '0);
        issue_tok.last  = issue && last_pair;
        issue_tok.bank  = TOK_BANK_W'(bank_q);
        issue_tok.g     = TOK_G_W'(g_q);
    end

    fc_sched_pipe #(
        .RD_LATENCY (RD_LATENCY),
        .MAC_LATENCY(MAC_LATENCY),
        .BANK_W     (MW),
        .G_W        (GW)
    ) u_pipe (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .issue_tok  (issue_tok),
        .mac_en     (mac_en),
        .accum_sload(accum_sload),
        .mux_sel    (mux_sel),
        .wb_en      (out_wr_en),
        .wb_g       (out_wr_addr),
        .empty      (pipe_empty)
    );

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign in_rden   = issue;
    assign w_rden    = issue;
    assign in_addr_a = addr_q;
    assign in_addr_b = addr_q;
    assign w_addr    = w_q;

endmodule

// File: tb/tb_fc_layer_scheduler.sv
// Self-checking bench: a pass is modelled as a count of non-stalled cycles since
// start, from which every issue, MAC, write-back and done event follows directly.
module tb_fc_layer_scheduler;

    localparam int INN   = 16;
    localparam int OUTN  = 4;
    localparam int PI    = 4;
    localparam int PO    = 2;
    localparam int RD    = 2;
    localparam int MACL  = 1;
    localparam int PPG   = INN / 2;
    localparam int PPB   = INN / (2 * PI);
    localparam int NG    = OUTN / PO;
    localparam int TOTAL = PPG * NG;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       busy, done, in_rden, w_rden, mac_en, accum_sload, out_wr_en;
    logic [0:0] in_addr_a, in_addr_b, out_wr_addr;
    logic [3:0] w_addr;
    logic [1:0] mux_sel;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int first_rden = -1;
    int done_q[$];
    int mdone_q[$];
    int wr_q[$];

    bit m_active  = 1'b0;
    bit m_donenow = 1'b0;
    int m_n       = 0;

    fc_layer_scheduler #(
        .INNEURON(INN), .OUTNEURON(OUTN), .PI(PI), .PO(PO),
        .RD_LATENCY(RD), .MAC_LATENCY(MACL)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .stall(stall),
        .busy(busy), .done(done), .in_rden(in_rden),
        .in_addr_a(in_addr_a), .in_addr_b(in_addr_b),
        .w_rden(w_rden), .w_addr(w_addr), .mux_sel(mux_sel),
        .mac_en(mac_en), .accum_sload(accum_sload),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        int cur, jm, jw;
        logic e_busy, e_done, e_rd, e_mac, e_sl, e_wr;
        int e_ia, e_w, e_mux, e_wa;
        e_busy = 0; e_done = 0; e_rd = 0; e_mac = 0; e_sl = 0; e_wr = 0;
        e_ia = 0; e_w = 0; e_mux = 0; e_wa = 0;
        if (reset) begin
            m_active = 0; m_donenow = 0; m_n = 0;
        end else if (m_donenow) begin
            e_done = 1;
        end else if (m_active) begin
            e_busy = 1;
            cur = m_n + (stall ? 0 : 1);
            if (!stall) begin
                if (cur >= 1 && cur <= TOTAL) begin
                    e_rd = 1; e_w = cur - 1; e_ia = ((cur - 1) % PPG) % PPB;
                end
                jm = cur - RD - 1;
                if (jm >= 0 && jm < TOTAL) begin
                    e_mac = 1; e_sl = (jm % PPG == 0); e_mux = (jm % PPG) / PPB;
                end
                jw = cur - RD - MACL - 1;
                if (jw >= 0 && jw < TOTAL && jw % PPG == PPG - 1) begin
                    e_wr = 1; e_wa = jw / PPG;
                end
            end
        end

        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("in_rden", in_rden, e_rd);
        chk("w_rden", w_rden, e_rd);
        chk("mac_en", mac_en, e_mac);
        chk("accum_sload", accum_sload, e_sl);
        chk("out_wr_en", out_wr_en, e_wr);
        if (e_rd || reset) begin
            chk("in_addr_a", in_addr_a, e_ia);
            chk("in_addr_b", in_addr_b, e_ia);
            chk("w_addr", w_addr, e_w);
        end
        if (e_mac || reset) chk("mux_sel", mux_sel, e_mux);
        if (e_wr || reset) chk("out_wr_addr", out_wr_addr, e_wa);

        if (done === 1'b1) done_q.push_back(cyc);
        if (e_done) mdone_q.push_back(cyc);
        if (out_wr_en === 1'b1) wr_q.push_back(cyc);
        if (in_rden === 1'b1 && first_rden < 0) first_rden = cyc;

        if (!reset) begin
            if (m_donenow) begin
                m_donenow = 0;
            end else if (m_active) begin
                if (!stall) m_n++;
                if (!stall && m_n == TOTAL + RD + MACL) begin
                    m_active = 0; m_donenow = 1;
                end
            end else if (start) begin
                m_active = 1; m_n = 0;
            end
        end
    end

    task automatic drive(input logic st, input logic sl, input logic rs);
        @(posedge clock);
        #1;
        start = st; stall = sl; reset = rs;
    endtask

    task automatic scen(input int kind, output int t0);
        logic st, sl, rs;
        done_q.delete(); mdone_q.delete(); wr_q.delete(); first_rden = -1;
        t0 = -1;
        for (int r = 0; r < 48; r++) begin
            st = (r == 0); sl = 0; rs = 0;
            case (kind)
                1: sl = (r == 5);
                2: sl = (r <= 4);
                3: st = (r == 0 || r == 8);
                4: begin st = (r == 0 || r == 12); rs = (r == 9); end
                5: st = (r == 0 || r == 21);
                default: ;
            endcase
            drive(st, sl, rs);
            if (r == 0) t0 = cyc;
        end
    endtask

    function automatic int qat(input int q[$], input int i, input int t0);
        return (q.size() > i) ? q[i] - t0 : -1;
    endfunction

    initial begin
        int t0;
        logic st, sl, rs;
        drive(0, 0, 1);
        drive(0, 0, 1);
        drive(0, 0, 0);
        drive(0, 0, 0);

        scen(0, t0);
        chk("nom_done_t", qat(done_q, 0, t0), 20);
        chk("nom_model_done_t", qat(mdone_q, 0, t0), 20);
        chk("nom_first_rden_t", first_rden - t0, 1);
        chk("nom_wr_count", wr_q.size(), 2);
        chk("nom_wr0_t", qat(wr_q, 0, t0), 11);
        chk("nom_wr1_t", qat(wr_q, 1, t0), 19);

        scen(1, t0);
        chk("stall1_done_t", qat(done_q, 0, t0), 21);

        scen(2, t0);
        chk("stall_hold_first_rden_t", first_rden - t0, 5);
        chk("stall_hold_done_count", done_q.size(), 1);

        scen(3, t0);
        chk("restart_done_count", done_q.size(), 1);
        chk("restart_done_t", qat(done_q, 0, t0), 20);

        scen(4, t0);
        chk("reset_done_count", done_q.size(), 1);
        chk("reset_done_t", qat(done_q, 0, t0), 32);

        scen(5, t0);
        chk("b2b_done_count", done_q.size(), 2);
        chk("b2b_done1_t", qat(done_q, 1, t0), 41);

        done_q.delete();
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 499) == 0);
            st = !rs && ($urandom_range(0, 7) == 0);
            sl = ($urandom_range(0, 3) == 0);
            drive(st, sl, rs);
        end
        for (int i = 0; i < 40; i++) drive(0, 0, 0);
        chk("random_passes_seen", done_q.size() > 5, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
